// File: rtl/fir_coeff_ctrl.sv
// FIR coefficient bank controller: shadow bank written by config, swapped into active bank at a tlast boundary.
// Latency: shadow write and swap land at the edge ending the request/boundary cycle; status outputs registered.
// No backpressure (stream handshake is only snooped); optional readback port under FIR_COEFF_CTRL_READBACK_EN.
module fir_coeff_ctrl #(
    parameter int COEFF_WIDTH = 24,
    parameter int NUM_TAPS    = 15,
    localparam int ADDR_WIDTH = $clog2(NUM_TAPS)
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            cfg_wr_en,
    input  logic [ADDR_WIDTH-1:0]           cfg_wr_addr,
    input  logic [COEFF_WIDTH-1:0]          cfg_wr_data,
    input  logic                            cfg_commit,
    input  logic                            cfg_abort,
    output logic                            cfg_busy,
    output logic                            cfg_err,
    output logic                            swap_done,
    input  logic                            s_axis_fir_tvalid,
    input  logic                            s_axis_fir_tready,
    input  logic                            s_axis_fir_tlast,
`ifdef FIR_COEFF_CTRL_READBACK_EN
    input  logic [ADDR_WIDTH-1:0]           cfg_rd_addr,
    output logic [COEFF_WIDTH-1:0]          cfg_rd_data,
`endif
    output logic [NUM_TAPS*COEFF_WIDTH-1:0] coeffs,
    output logic [15:0]                     last_frame_len
);

    typedef enum logic {IDLE, PENDING} state_t;

    state_t                          state, state_nxt;
    logic [NUM_TAPS*COEFF_WIDTH-1:0] shadow;
    logic [15:0]                     beat_cnt;
    logic [15:0]                     beat_cnt_inc;
    logic                            beat, boundary;
    logic                            wr_in_range;
    logic                            shadow_we, err_nxt, swap_nxt;

    assign beat         = s_axis_fir_tvalid & s_axis_fir_tready;
    assign boundary     = beat & s_axis_fir_tlast;
    assign wr_in_range  = (32'(cfg_wr_addr) < NUM_TAPS);
    assign beat_cnt_inc = (beat_cnt == 16'hFFFF) ? 16'hFFFF : beat_cnt + 16'd1;

    always_comb begin
        state_nxt = state;
        shadow_we = 1'b0;
        err_nxt   = 1'b0;
        swap_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_wr_en) begin
                    if (wr_in_range) shadow_we = 1'b1;
                    else             err_nxt   = 1'b1;
                end
                if (cfg_commit) state_nxt = PENDING;
            end
            PENDING: begin
                if (cfg_wr_en || cfg_commit) err_nxt = 1'b1;
                // Abort takes priority over a coincident boundary.
                if (cfg_abort) begin
                    state_nxt = IDLE;
                end else if (boundary) begin
                    swap_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cfg_busy  <= 1'b0;
            cfg_err   <= 1'b0;
            swap_done <= 1'b0;
            shadow    <= '0;
            coeffs    <= '0;
        end else begin
            state     <= state_nxt;
            cfg_busy  <= (state_nxt == PENDING);
            cfg_err   <= err_nxt;
            swap_done <= swap_nxt;
            if (shadow_we)
                shadow[32'(cfg_wr_addr)*COEFF_WIDTH +: COEFF_WIDTH] <= cfg_wr_data;
            if (swap_nxt)
                coeffs <= shadow;
        end
    end

    // Frame length tracking runs regardless of commit state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beat_cnt       <= 16'd0;
            last_frame_len <= 16'd0;
        end else if (boundary) begin
            beat_cnt       <= 16'd0;
            last_frame_len <= beat_cnt_inc;
        end else if (beat) begin
            beat_cnt       <= beat_cnt_inc;
        end
    end

`ifdef FIR_COEFF_CTRL_READBACK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cfg_rd_data <= '0;
        else if (32'(cfg_rd_addr) < NUM_TAPS)
            cfg_rd_data <= coeffs[32'(cfg_rd_addr)*COEFF_WIDTH +: COEFF_WIDTH];
        else
            cfg_rd_data <= '0;
    end
`else
    // Readback path not built.
`endif

endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// Directed self-checking bench for fir_coeff_ctrl.
module tb_fir_coeff_ctrl;

    localparam int CW = 24;
    localparam int NT = 15;
    localparam int AW = $clog2(NT);
    localparam int BW = NT*CW;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cfg_wr_en;
    logic [AW-1:0] cfg_wr_addr;
    logic [CW-1:0] cfg_wr_data;
    logic          cfg_commit;
    logic          cfg_abort;
    logic          cfg_busy;
    logic          cfg_err;
    logic          swap_done;
    logic          tvalid, tready, tlast;
    logic [BW-1:0] coeffs;
    logic [15:0]   last_frame_len;
`ifdef FIR_COEFF_CTRL_READBACK_EN
    logic [AW-1:0] cfg_rd_addr;
    logic [CW-1:0] cfg_rd_data;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [BW-1:0] bank;

    always #5 clk = ~clk;

    fir_coeff_ctrl dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .cfg_wr_en         (cfg_wr_en),
        .cfg_wr_addr       (cfg_wr_addr),
        .cfg_wr_data       (cfg_wr_data),
        .cfg_commit        (cfg_commit),
        .cfg_abort         (cfg_abort),
        .cfg_busy          (cfg_busy),
        .cfg_err           (cfg_err),
        .swap_done         (swap_done),
        .s_axis_fir_tvalid (tvalid),
        .s_axis_fir_tready (tready),
        .s_axis_fir_tlast  (tlast),
`ifdef FIR_COEFF_CTRL_READBACK_EN
        .cfg_rd_addr       (cfg_rd_addr),
        .cfg_rd_data       (cfg_rd_data),
`endif
        .coeffs            (coeffs),
        .last_frame_len    (last_frame_len)
    );

    task automatic chk(input string tag, input logic [383:0] got, input logic [383:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge, then settle so outputs are sampled away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cfg_wr_en   = 1'b0;
        cfg_wr_addr = '0;
        cfg_wr_data = '0;
        cfg_commit  = 1'b0;
        cfg_abort   = 1'b0;
        tvalid      = 1'b0;
        tready      = 1'b0;
        tlast       = 1'b0;
    endtask

    task automatic wr(input int addr, input logic [CW-1:0] data);
        cfg_wr_en   = 1'b1;
        cfg_wr_addr = AW'(addr);
        cfg_wr_data = data;
        step();
        cfg_wr_en   = 1'b0;
    endtask

    task automatic commit();
        cfg_commit = 1'b1;
        step();
        cfg_commit = 1'b0;
    endtask

    task automatic send_beat(input logic last);
        tvalid = 1'b1;
        tready = 1'b1;
        tlast  = last;
        step();
        tvalid = 1'b0;
        tready = 1'b0;
        tlast  = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        idle_inputs();
`ifdef FIR_COEFF_CTRL_READBACK_EN
        cfg_rd_addr = '0;
`endif
        step(); step();
        chk("rst_coeffs", coeffs, 0);
        chk("rst_busy", cfg_busy, 0);
        chk("rst_err", cfg_err, 0);
        chk("rst_swap", swap_done, 0);
        chk("rst_lfl", last_frame_len, 0);
        reset_n = 1'b1;
        step();

        // Basic load: taps k = k+1, swap at the tlast of a 4-beat frame.
        bank = '0;
        for (int k = 0; k < NT; k++) begin
            wr(k, CW'(k + 1));
            bank[k*CW +: CW] = CW'(k + 1);
        end
        chk("wr_err", cfg_err, 0);
        commit();
        chk("commit_busy", cfg_busy, 1);
        for (int b = 1; b <= 3; b++) send_beat(1'b0);
        chk("pre_swap_coeffs", coeffs, 0);
        send_beat(1'b1);
        chk("swap_coeffs", coeffs, bank);
        chk("swap_done", swap_done, 1);
        chk("swap_busy", cfg_busy, 0);
        chk("lfl4", last_frame_len, 4);
        step();
        chk("swap_done_1cyc", swap_done, 0);

        // Commit coincident with a boundary waits for the next boundary.
        wr(0, 24'hABCDEF);
        bank[0 +: CW] = 24'hABCDEF;
        cfg_commit = 1'b1;
        send_beat(1'b1);
        cfg_commit = 1'b0;
        chk("cb_busy", cfg_busy, 1);
        chk("cb_no_swap", swap_done, 0);
        chk("cb_lfl1", last_frame_len, 1);
        step(); step();
        chk("cb_gap_busy", cfg_busy, 1);
        send_beat(1'b0);
        chk("cb_gap_coeffs", coeffs[CW-1:0], 24'h000001);
        send_beat(1'b1);
        chk("cb_swap_coeffs", coeffs, bank);
        chk("cb_swap_done", swap_done, 1);
        chk("cb_lfl2", last_frame_len, 2);

        // Writes and a second commit while pending are rejected.
        wr(5, 24'h123456);
        bank[5*CW +: CW] = 24'h123456;
        commit();
        wr(3, 24'h7FFFFF);
        chk("pend_wr_err", cfg_err, 1);
        step();
        chk("pend_err_clear", cfg_err, 0);
        commit();
        chk("pend_commit_err", cfg_err, 1);
        chk("pend_still_busy", cfg_busy, 1);
        send_beat(1'b1);
        chk("pend_swap_coeffs", coeffs, bank);
        chk("pend_tap3", coeffs[3*CW +: CW], 24'h000004);

        // Out-of-range write, then abort coincident with a boundary.
        wr(15, 24'hDEAD01);
        chk("oor_err", cfg_err, 1);
        wr(14, 24'h800000);
        chk("inr_err", cfg_err, 0);
        commit();
        cfg_abort = 1'b1;
        send_beat(1'b1);
        cfg_abort = 1'b0;
        chk("abort_busy", cfg_busy, 0);
        chk("abort_no_swap", swap_done, 0);
        chk("abort_coeffs", coeffs, bank);
        chk("abort_lfl1", last_frame_len, 1);
        cfg_abort = 1'b1;
        step();
        cfg_abort = 1'b0;
        chk("idle_abort_err", cfg_err, 0);
        commit();
        send_beat(1'b1);
        bank[14*CW +: CW] = 24'h800000;
        chk("retained_swap", coeffs, bank);
        chk("retained_done", swap_done, 1);

        // Reset while pending discards the commit and clears everything.
        wr(0, 24'h000111);
        commit();
        send_beat(1'b0);
        send_beat(1'b0);
        chk("pre_rst_busy", cfg_busy, 1);
        reset_n = 1'b0;
        #2;
        chk("async_rst_coeffs", coeffs, 0);
        chk("async_rst_busy", cfg_busy, 0);
        step(); step();
        reset_n = 1'b1;
        step();
        send_beat(1'b0);
        send_beat(1'b0);
        send_beat(1'b1);
        chk("post_rst_no_swap", swap_done, 0);
        chk("post_rst_coeffs", coeffs, 0);
        chk("post_rst_lfl3", last_frame_len, 3);
        chk("post_rst_busy", cfg_busy, 0);

`ifdef FIR_COEFF_CTRL_READBACK_EN
        wr(7, 24'hFFF000);
        commit();
        send_beat(1'b1);
        cfg_rd_addr = AW'(7);
        step();
        chk("rd_tap7", cfg_rd_data, 24'hFFF000);
        cfg_rd_addr = AW'(15);
        step();
        chk("rd_oor", cfg_rd_data, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
